// File: rtl/fp_mult_result_queue_if.sv
// Result handshake bundle between the multiplier side, the queue and its consumer.
interface fp_mult_result_queue_if;
    logic        in_valid;
    logic [31:0] in_z;
    logic [7:0]  in_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [7:0]  out_status;

    // Producer/consumer side (drives results in, accepts entries out)
    modport master (
        output in_valid, in_z, in_status, out_ready,
        input  out_valid, out_z, out_status
    );

    // Queue side
    modport slave (
        input  in_valid, in_z, in_status, out_ready,
        output out_valid, out_z, out_status
    );
endinterface

// File: rtl/fp_mult_result_queue.sv
// Show-ahead result FIFO behind the single-precision multiplier.
// Drops results when full (sticky overflow), counts NaN results, and with
// FPM_RESULT_STICKY_FLAGS_EN defined accumulates sticky exception flags.
module fp_mult_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fp_mult_result_queue_if.slave    bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         nan_count
`ifdef FPM_RESULT_STICKY_FLAGS_EN
    ,
    output logic [7:0]               sticky_flags,
    input  logic                     flags_clr
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 40;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               push;
    logic               pop;

    // Handshake decode; head is driven straight from storage, gated to 0 when empty
    assign full          = (level == LVL_W'(DEPTH));
    assign bus.out_valid = (level != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = bus.in_valid && (!full || pop);
    assign head          = mem[rd_ptr];
    assign bus.out_z      = bus.out_valid ? head[39:8] : 32'd0;
    assign bus.out_status = bus.out_valid ? head[7:0]  : 8'd0;

    // Entry storage, no reset needed: reads are masked by level
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_z, bus.in_status};
        end
    end

    // Pointers, occupancy, overflow and NaN counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            nan_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (bus.in_valid && !push) begin
                overflow <= 1'b1;
            end
            if (push && bus.in_status[2] && (nan_count != {CNT_W{1'b1}})) begin
                nan_count <= nan_count + CNT_W'(1);
            end
        end
    end

`ifdef FPM_RESULT_STICKY_FLAGS_EN
    // Sticky exception flags; a clear coinciding with a push keeps that entry's flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= 8'd0;
        end else if (flags_clr) begin
            sticky_flags <= push ? {2'b00, bus.in_status[5:0]} : 8'd0;
        end else if (push) begin
            sticky_flags <= sticky_flags | {2'b00, bus.in_status[5:0]};
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_result_queue.sv
// Scoreboard bench for fp_mult_result_queue (DEPTH=4, CNT_W=16).
module tb_fp_mult_result_queue;

    logic        clk;
    logic        rst;
    logic [2:0]  level;
    logic        overflow;
    logic [15:0] nan_count;
`ifdef FPM_RESULT_STICKY_FLAGS_EN
    logic [7:0]  sticky_flags;
    logic        flags_clr;
`endif

    fp_mult_result_queue_if bus ();

    fp_mult_result_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .level        (level),
        .overflow     (overflow),
        .nan_count    (nan_count)
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        ,
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] exp_q[$];
    int          m_level;
    logic        m_ovf;
    logic [15:0] m_nan;
    logic [7:0]  m_sticky;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted head entry against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", {24'd0, bus.out_z, bus.out_status}, 64'hDEAD);
                    end else begin
                        check("out_entry", {24'd0, bus.out_z, bus.out_status},
                              {24'd0, exp_q.pop_front()});
                    end
                end else if (!bus.out_valid) begin
                    check("idle_zero", {24'd0, bus.out_z, bus.out_status}, 64'd0);
                end
            end
        end
    end

    // One clock of stimulus; updates the reference model for the same edge
    task automatic cyc(input logic v, input logic [31:0] z, input logic [7:0] s, input logic rdy);
        logic p_pop;
        logic p_push;
        logic clr;
        bus.in_valid  = v;
        bus.in_z      = z;
        bus.in_status = s;
        bus.out_ready = rdy;
        clr = 1'b0;
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        clr = flags_clr;
`endif
        p_pop  = (m_level > 0) && rdy;
        p_push = v && ((m_level < 4) || p_pop);
        if (p_push) exp_q.push_back({z, s});
        if (v && !p_push) m_ovf = 1'b1;
        if (p_push && s[2] && m_nan != 16'hFFFF) m_nan++;
        if (clr) m_sticky = p_push ? {2'b00, s[5:0]} : 8'd0;
        else if (p_push) m_sticky = m_sticky | {2'b00, s[5:0]};
        m_level = m_level + int'(p_push) - int'(p_pop);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        if (clr) begin end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_z      = 32'h7FC00000;
        bus.in_status = 8'h04;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        m_level  = 0;
        m_ovf    = 1'b0;
        m_nan    = 16'd0;
        m_sticky = 8'd0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_level > 0; i++) begin
            cyc(1'b0, 32'd0, 8'd0, 1'b1);
        end
        check("drain_level", 64'(level), 64'd0);
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_z      = 32'd0;
        bus.in_status = 8'd0;
        bus.out_ready = 1'b0;
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        m_level = 0;
        m_ovf = 1'b0;
        m_nan = 16'd0;
        m_sticky = 8'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_nan", 64'(nan_count), 64'd0);
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        check("rst_sticky", 64'(sticky_flags), 64'd0);
`endif

        // Single push, out_ready low: visible next cycle
        cyc(1'b1, 32'h3F800000, 8'h00, 1'b0);
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_z", 64'(bus.out_z), 64'h3F800000);
        check("t1_level", 64'(level), 64'd1);
        drain();

        // Five pushes into a 4-deep queue: fifth dropped
        do_reset();
        cyc(1'b1, 32'h40000000, 8'h00, 1'b0);
        cyc(1'b1, 32'h40400000, 8'h01, 1'b0);
        cyc(1'b1, 32'h40800000, 8'h02, 1'b0);
        cyc(1'b1, 32'h40A00000, 8'h03, 1'b0);
        cyc(1'b1, 32'h40C00000, 8'h04, 1'b0);
        check("t2_level", 64'(level), 64'd4);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_nan_drop", 64'(nan_count), 64'd0);
        check("t2_head", 64'(bus.out_z), 64'h40000000);
        drain();
        check("t2_overflow_held", 64'(overflow), 64'd1);

        // Full queue with simultaneous push and pop
        do_reset();
        cyc(1'b1, 32'h11111111, 8'h00, 1'b0);
        cyc(1'b1, 32'h22222222, 8'h00, 1'b0);
        cyc(1'b1, 32'h33333333, 8'h00, 1'b0);
        cyc(1'b1, 32'h44444444, 8'h00, 1'b0);
        cyc(1'b1, 32'h55555555, 8'hC0, 1'b1);
        check("t3_level", 64'(level), 64'd4);
        check("t3_overflow", 64'(overflow), 64'd0);
        check("t3_head", 64'(bus.out_z), 64'h22222222);
        drain();

        // NaN counting and sticky flags
        do_reset();
        cyc(1'b1, 32'h7FC00000, 8'h04, 1'b1);
        cyc(1'b1, 32'h7FC00001, 8'h06, 1'b1);
        cyc(1'b1, 32'h00000001, 8'h20, 1'b1);
        check("t4_nan", 64'(nan_count), 64'd2);
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        check("t4_sticky", 64'(sticky_flags), 64'h26);
        flags_clr = 1'b1;
        cyc(1'b1, 32'h00000000, 8'h01, 1'b1);
        check("t4_sticky_clr_push", 64'(sticky_flags), 64'h01);
        flags_clr = 1'b1;
        cyc(1'b0, 32'h00000000, 8'h00, 1'b1);
        check("t4_sticky_clr", 64'(sticky_flags), 64'h00);
`endif
        drain();

        // Reset with three entries held
        do_reset();
        cyc(1'b1, 32'h7FC00000, 8'h04, 1'b0);
        cyc(1'b1, 32'h3F000000, 8'h00, 1'b0);
        cyc(1'b1, 32'h3E800000, 8'h00, 1'b0);
        check("t5_level_pre", 64'(level), 64'd3);
        do_reset();
        check("t5_valid", 64'(bus.out_valid), 64'd0);
        check("t5_level", 64'(level), 64'd0);
        check("t5_nan", 64'(nan_count), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);

        // Random streaming against the reference model
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom % 4) != 0, $urandom, 8'($urandom % 256), 1'($urandom % 2));
            check("rand_level", 64'(level), 64'(m_level));
        end
        check("rand_overflow", 64'(overflow), 64'(m_ovf));
        check("rand_nan", 64'(nan_count), 64'(m_nan));
`ifdef FPM_RESULT_STICKY_FLAGS_EN
        check("rand_sticky", 64'(sticky_flags), 64'(m_sticky));
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
